inc_driver: RTL and testbench
=============================

# inc_driver

Transmitter side of the counter increment interface: it generates the per-cycle `inc` stream that the accumulating counter consumes. Given a target total and a maximum step size, it emits increments under a valid/ready handshake until the target has been delivered. It then waits for the counter's register latency and checks the observed `count` against the expected sum. It is used as the stimulus/self-check partner of the counter block in simulation-driven regression.

## Interface
- `WIDTH`, 8: width of `inc`, `count`, target and totals
- `CHECK_DELAY`, 1: cycles to wait after the last transfer before sampling `count_obs` (≥1)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `target`  in  WIDTH  total amount to deliver; latched on accepted `start`
- `step`  in  WIDTH  max increment per beat; latched on accepted `start`; 0 is treated as 1
- `inc_ready`  in  1  consumer accepts the current beat
- `count_obs`  in  WIDTH  counter value observed from the consumer
- `inc`  out  WIDTH  increment value; 0 whenever `inc_valid`=0
- `inc_valid`  out  1  beat valid
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a run
- `sent_total`  out  WIDTH  sum of accepted beats this run, mod 2^WIDTH
- `mismatch`  out  1  sticky check failure; cleared on accepted `start` or reset

## Operation
- States: IDLE, SEND, CHECK, DONE.
- IDLE:
  - `start`=1 latches `target`, `step` (0→1), `remaining`=`target`, and `base`=`count_obs`.
  - It also clears `sent_total` and `mismatch`.
  - Next state is SEND if `target`≠0, else CHECK.
- SEND:
  - `inc_valid`=1, `inc`=min(step, remaining).
  - On `inc_valid & inc_ready`: `remaining` -= `inc`, `sent_total` += `inc`.
  - If the new `remaining`=0, go to CHECK and load the delay counter with `CHECK_DELAY`.
  - While not ready, `inc` and `inc_valid` hold stable.
- CHECK:
  - `inc_valid`=0, `inc`=0; the delay counter decrements each cycle.
  - When it reaches 0 (last CHECK cycle), compare `count_obs` with (`base`+`target`) mod 2^WIDTH; inequality sets `mismatch`.
  - Then go to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- `start` outside IDLE is ignored.
- All additions are modulo 2^WIDTH; wrap of the counter is expected and not an error (base 0xF0 + target 0x20 expects 0x10).
- `remaining` never underflows: the beat size is clamped by min().

## Timing
- Reset value of all outputs is 0; state is IDLE, and internal registers (`remaining`, `base`, delay counter) are 0.
- Reset asserted mid-run aborts immediately: the next cycle is IDLE with all outputs 0 and no `done` pulse.
- An accepted `start` in cycle N gives `inc_valid`=1 in N+1.
- With `inc_ready` held high, beats are back-to-back: ceil(target/step) beats in N+1 … N+k.
- The last handshake in cycle M gives CHECK in M+1 … M+CHECK_DELAY, compare in M+CHECK_DELAY, and `done` in M+CHECK_DELAY+1.
- With `target`=0: CHECK in N+1 … N+CHECK_DELAY, `done` in N+CHECK_DELAY+1.
- `mismatch` updates in the cycle after the compare, alongside `done`, and holds until the next accepted `start`.
- `sent_total` updates the cycle after each handshake and holds after DONE.

## Structure
- Shared package holds:
  - the state enum (IDLE/SEND/CHECK/DONE);
  - the default `WIDTH`=8;
  - the default `CHECK_DELAY`=1.
- Single flat module; no sub-module is warranted. The min() clamp and the compare are inline combinational logic.
- Delay counter width is $clog2(CHECK_DELAY+1).

## Test plan
- Reset, then idle: all outputs 0; `busy`=0 and no beats after 10 cycles.
- `target`=10, `step`=3, ready held high, counter base 0:
  - beats 3,3,3,1 in consecutive cycles;
  - `sent_total`=10, `count_obs`=10 at compare;
  - `done` pulse, `mismatch`=0.
- Same run with `inc_ready` toggling 1,0,0,1,…: `inc` stays stable across stalled cycles; the beat sequence and final `sent_total`=10 are unchanged.
- Wrap: base `count_obs`=0xF0, `target`=0x20, `step`=0x10 → expected 0x10; `mismatch`=0.
- Edge cases:
  - `target`=0 → no beats, `done` at N+2 with `CHECK_DELAY`=1;
  - `step`=0 with `target`=2 → beats 1,1.
- Fault and abort:
  - bench forces `count_obs` off by 1 at compare → `mismatch`=1, sticky until the next `start`;
  - reset asserted after the second beat → IDLE next cycle, no `done`.

Source files
------------

// File: rtl/inc_driver_pkg.sv
// Shared definitions for the increment driver.
//   state_e           : driver FSM states
//   DefaultWidth      : default width of inc / count / totals
//   DefaultCheckDelay : default cycles between last transfer and count check
package inc_driver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth      = 8;
  localparam int unsigned DefaultCheckDelay = 1;

endpackage

// File: rtl/inc_driver.sv
// Increment driver: streams increments summing to a target total under a
// valid/ready handshake, waits for the consumer's register latency, then checks
// the observed count against base + target.
// Ports:
//   clock, reset           : clock and synchronous active-high reset
//   start, target, step    : run request and its parameters (latched in idle)
//   inc_ready, count_obs   : consumer handshake and observed counter value
//   inc, inc_valid         : increment beat (inc is 0 when not valid)
//   busy, done             : activity flag and end-of-run pulse
//   sent_total, mismatch   : sum of accepted beats, sticky check failure
module inc_driver
  import inc_driver_pkg::*;
#(
  parameter int unsigned WIDTH       = DefaultWidth,
  parameter int unsigned CHECK_DELAY = DefaultCheckDelay
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  input  logic             inc_ready,
  input  logic [WIDTH-1:0] count_obs,
  output logic [WIDTH-1:0] inc,
  output logic             inc_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sent_total,
  output logic             mismatch
);

  localparam int unsigned DlyW = $clog2(CHECK_DELAY + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic             mismatch_q, mismatch_d;
  logic [DlyW-1:0]  dly_q, dly_d;

  logic [WIDTH-1:0] beat;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] expected_sum;

  // Clamp the beat so remaining can never underflow.
  assign beat         = (step_q < remaining_q) ? step_q : remaining_q;
  assign rem_next     = remaining_q - beat;
  assign expected_sum = base_q + target_q;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    base_d      = base_q;
    sent_d      = sent_q;
    mismatch_d  = mismatch_q;
    dly_d       = dly_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d    = target;
          step_d      = (step == '0) ? WIDTH'(1) : step;
          remaining_d = target;
          base_d      = count_obs;
          sent_d      = '0;
          mismatch_d  = 1'b0;
          if (target != '0) begin
            state_d = StSend;
          end else begin
            state_d = StCheck;
            dly_d   = DlyW'(CHECK_DELAY);
          end
        end
      end
      StSend: begin
        if (inc_ready) begin
          remaining_d = rem_next;
          sent_d      = sent_q + beat;
          if (rem_next == '0) begin
            state_d = StCheck;
            dly_d   = DlyW'(CHECK_DELAY);
          end
        end
      end
      StCheck: begin
        dly_d = dly_q - DlyW'(1);
        // Last check cycle: counter has had CHECK_DELAY cycles to settle.
        if (dly_q == DlyW'(1)) begin
          if (count_obs != expected_sum) begin
            mismatch_d = 1'b1;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      target_q    <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      base_q      <= '0;
      sent_q      <= '0;
      mismatch_q  <= 1'b0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      base_q      <= base_d;
      sent_q      <= sent_d;
      mismatch_q  <= mismatch_d;
      dly_q       <= dly_d;
    end
  end

  assign inc_valid  = (state_q == StSend);
  assign inc        = inc_valid ? beat : '0;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign sent_total = sent_q;
  assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_inc_driver.sv
// Self-checking bench for inc_driver: table of directed runs plus hand-written
// reset/idle, sticky-mismatch and mid-run abort sequences.
module tb_inc_driver;

  localparam int unsigned W  = 8;
  localparam int unsigned CD = 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] target;
  logic [W-1:0] step;
  logic         inc_ready;
  logic [W-1:0] count_obs;
  logic [W-1:0] inc;
  logic         inc_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] sent_total;
  logic         mismatch;

  logic [W-1:0] cnt;    // consumer counter model
  logic [W-1:0] fault;  // offset injected onto count_obs

  assign count_obs = cnt + fault;

  always #5 clock = ~clock;

  inc_driver #(
    .WIDTH      (W),
    .CHECK_DELAY(CD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .target    (target),
    .step      (step),
    .inc_ready (inc_ready),
    .count_obs (count_obs),
    .inc       (inc),
    .inc_valid (inc_valid),
    .busy      (busy),
    .done      (done),
    .sent_total(sent_total),
    .mismatch  (mismatch)
  );

  // beats[0] is the first beat: list in concatenation as {b3, b2, b1, b0}.
  typedef struct {
    logic [W-1:0]      target;
    logic [W-1:0]      step;
    logic [7:0]        ready;   // ready pattern, bit (cycle % 8)
    logic [W-1:0]      base;
    logic [W-1:0]      fault;
    logic [3:0][W-1:0] beats;
    int                nbeats;
    logic [W-1:0]      total;
    logic              mm;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int           idx;
    int           last_hs;
    int           done_it;
    logic         prev_stall;
    logic         rdy;
    logic [W-1:0] pinc;
    logic [W-1:0] hs_val;
    cnt       = v.base;
    fault     = '0;
    target    = v.target;
    step      = v.step;
    inc_ready = 1'b0;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    fault = v.fault;
    chk("mismatch_cleared", {31'd0, mismatch}, 32'd0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    idx        = 0;
    last_hs    = -1;
    done_it    = -1;
    prev_stall = 1'b0;
    pinc       = '0;
    for (int it = 0; it < 200; it++) begin
      if (done) begin
        done_it = it;
        break;
      end
      hs_val = '0;
      if (inc_valid) begin
        if (prev_stall) chk("stall_hold", {24'd0, inc}, {24'd0, pinc});
        if (idx < v.nbeats) chk("beat", {24'd0, inc}, {24'd0, v.beats[idx]});
        else chk("extra_beat", {31'd0, inc_valid}, 32'd0);
        rdy        = v.ready[it % 8];
        inc_ready  = rdy;
        prev_stall = ~rdy;
        pinc       = inc;
        if (rdy) begin
          last_hs = it;
          idx++;
          hs_val = inc;
        end
      end else begin
        inc_ready  = 1'b0;
        prev_stall = 1'b0;
      end
      @(negedge clock);
      cnt = cnt + hs_val;
    end
    inc_ready = 1'b0;
    chk("done_latency", done_it, last_hs + CD + 1);
    if (v.ready == 8'hff) chk("done_abs", done_it, v.nbeats + CD);
    chk("beat_count", idx, v.nbeats);
    chk("sent_total", {24'd0, sent_total}, {24'd0, v.total});
    chk("mismatch", {31'd0, mismatch}, {31'd0, v.mm});
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    chk("valid_at_done", {31'd0, inc_valid}, 32'd0);
    @(negedge clock);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("sent_hold", {24'd0, sent_total}, {24'd0, v.total});
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{target: 8'd10, step: 8'd3, ready: 8'hff, base: 8'h00, fault: 8'd0,
               beats: {8'd1, 8'd3, 8'd3, 8'd3}, nbeats: 4, total: 8'd10, mm: 1'b0};
    tbl[1] = '{target: 8'd10, step: 8'd3, ready: 8'h99, base: 8'h0a, fault: 8'd0,
               beats: {8'd1, 8'd3, 8'd3, 8'd3}, nbeats: 4, total: 8'd10, mm: 1'b0};
    tbl[2] = '{target: 8'h20, step: 8'h10, ready: 8'hff, base: 8'hf0, fault: 8'd0,
               beats: {8'd0, 8'd0, 8'h10, 8'h10}, nbeats: 2, total: 8'h20, mm: 1'b0};
    tbl[3] = '{target: 8'd0, step: 8'd5, ready: 8'hff, base: 8'h33, fault: 8'd0,
               beats: {8'd0, 8'd0, 8'd0, 8'd0}, nbeats: 0, total: 8'd0, mm: 1'b0};
    tbl[4] = '{target: 8'd2, step: 8'd0, ready: 8'hff, base: 8'h40, fault: 8'd0,
               beats: {8'd0, 8'd0, 8'd1, 8'd1}, nbeats: 2, total: 8'd2, mm: 1'b0};
    tbl[5] = '{target: 8'd5, step: 8'd2, ready: 8'hff, base: 8'h07, fault: 8'd1,
               beats: {8'd0, 8'd1, 8'd2, 8'd2}, nbeats: 3, total: 8'd5, mm: 1'b1};
    tbl[6] = '{target: 8'd1, step: 8'd1, ready: 8'hff, base: 8'h55, fault: 8'd0,
               beats: {8'd0, 8'd0, 8'd0, 8'd1}, nbeats: 1, total: 8'd1, mm: 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    target    = '0;
    step      = '0;
    inc_ready = 1'b0;
    cnt       = '0;
    fault     = '0;
    repeat (2) @(negedge clock);
    chk("rst_inc", {24'd0, inc}, 32'd0);
    chk("rst_valid", {31'd0, inc_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sent", {24'd0, sent_total}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_quiet", {30'd0, busy, inc_valid}, 32'd0);
    end

    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Mismatch from the faulted run stays set while idle.
    fault = '0;
    repeat (5) @(negedge clock);
    chk("mismatch_sticky", {31'd0, mismatch}, 32'd1);
    run(tbl[6]);

    // Abort mid-run; a start while busy must be ignored.
    cnt       = '0;
    target    = 8'd10;
    step      = 8'd3;
    inc_ready = 1'b1;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("abort_beat0", {24'd0, inc}, 32'd3);
    @(negedge clock);
    chk("abort_beat1", {24'd0, inc}, 32'd3);
    start  = 1'b1;
    target = 8'd1;
    step   = 8'd1;
    @(negedge clock);
    start = 1'b0;
    chk("start_ignored", {24'd0, inc}, 32'd3);
    chk("abort_sent", {24'd0, sent_total}, 32'd6);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    inc_ready = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, inc_valid}, 32'd0);
    chk("abort_inc", {24'd0, inc}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sent0", {24'd0, sent_total}, 32'd0);
    chk("abort_mm", {31'd0, mismatch}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("abort_no_done", {30'd0, done, busy}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
